// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, writeback
// source codes, the decoded control bundle and immediate extraction.
package rv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_PASSB = 4'b1001;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // IMM_NONE is the zero encoding so an all-zero control bundle yields imm 0.
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       illegal;
        imm_sel_t   imm_sel;
    } ctrl_t;

    function automatic logic [31:0] gen_imm(input imm_sel_t sel, input logic [31:0] instr);
        logic [31:0] imm;
        imm = '0;
        case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile.sv
// 2-read/1-write register file with x0 tied to zero and a same-cycle
// write-through bypass so decode sees the value being written back.
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   addr1,
    input  logic [AW-1:0]   addr2,
    input  logic            write_en,
    input  logic [AW-1:0]   write_addr,
    input  logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en && (write_addr != '0)) begin
            regs[write_addr] <= write_data;
        end
    end

    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (addr1 != '0) begin
            read_data1 = (write_en && (addr1 == write_addr)) ? write_data : regs[addr1];
        end
        if (addr2 != '0) begin
            read_data2 = (write_en && (addr2 == write_addr)) ? write_data : regs[addr2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: control/immediate decode, register read, early
// BEQ/BNE/JAL resolution back to fetch, and the ID/EX pipeline register.
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCPD,
    input  logic            RegWriteW,
    input  logic [4:0]      WriteRegW,
    input  logic [XLEN-1:0] ResultW,
    input  logic [XLEN-1:0] ALUOutM,
    input  logic            ForwardAD,
    input  logic            ForwardBD,
    input  logic            FlushE,
    output logic            PCSrcD,
    output logic [XLEN-1:0] PCBranchD,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ALUSrcE,
    output logic            IllegalE,
    output logic [1:0]      ResultSrcE,
    output logic [3:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmE,
    output logic [XLEN-1:0] PCPE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE
);

    ctrl_t           ctrl;
    logic            legal;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            f7_zero;
    logic            f7_alt;
    logic [XLEN-1:0] rd1, rd2, cmp_a, cmp_b, imm, imm_b, imm_j;

    assign opcode  = InstrD[6:0];
    assign funct3  = InstrD[14:12];
    assign f7_zero = (InstrD[31:25] == 7'b0000000);
    assign f7_alt  = (InstrD[31:25] == 7'b0100000);
    assign Rs1D    = InstrD[19:15];
    assign Rs2D    = InstrD[24:20];

    regfile #(.XLEN(XLEN), .NREG(NREG), .AW(5)) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr1      (Rs1D),
        .addr2      (Rs2D),
        .write_en   (RegWriteW),
        .write_addr (WriteRegW),
        .write_data (ResultW),
        .read_data1 (rd1),
        .read_data2 (rd2)
    );

    always_comb begin
        ctrl  = '0;
        legal = 1'b0;
        case (opcode)
            OP: begin
                ctrl.reg_write = 1'b1;
                legal = f7_zero || (f7_alt && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                case (funct3)
                    3'b000:  ctrl.alu_control = f7_alt ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl.alu_control = ALU_SLL;
                    3'b010:  ctrl.alu_control = ALU_SLT;
                    3'b100:  ctrl.alu_control = ALU_XOR;
                    3'b101:  ctrl.alu_control = f7_alt ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl.alu_control = ALU_OR;
                    3'b111:  ctrl.alu_control = ALU_AND;
                    default: legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_sel   = IMM_I;
                legal = 1'b1;
                case (funct3)
                    3'b000: ctrl.alu_control = ALU_ADD;
                    3'b010: ctrl.alu_control = ALU_SLT;
                    3'b100: ctrl.alu_control = ALU_XOR;
                    3'b110: ctrl.alu_control = ALU_OR;
                    3'b111: ctrl.alu_control = ALU_AND;
                    3'b001: begin
                        ctrl.alu_control = ALU_SLL;
                        legal = f7_zero;
                    end
                    3'b101: begin
                        ctrl.alu_control = f7_alt ? ALU_SRA : ALU_SRL;
                        legal = f7_zero || f7_alt;
                    end
                    default: legal = 1'b0;
                endcase
            end
            LOAD: begin
                legal           = (funct3 == 3'b010);
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
                ctrl.imm_sel    = IMM_I;
                ctrl.alu_control = ALU_ADD;
            end
            STORE: begin
                legal           = (funct3 == 3'b010);
                ctrl.mem_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_sel    = IMM_S;
                ctrl.alu_control = ALU_ADD;
            end
            BRANCH: begin
                legal           = (funct3 == 3'b000) || (funct3 == 3'b001);
                ctrl.branch     = 1'b1;
                ctrl.branch_ne  = funct3[0];
                ctrl.imm_sel    = IMM_B;
                ctrl.alu_control = ALU_SUB;
            end
            JAL: begin
                legal           = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_PC4;
                ctrl.jump       = 1'b1;
                ctrl.imm_sel    = IMM_J;
            end
            LUI: begin
                legal           = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.imm_sel    = IMM_U;
                ctrl.alu_control = ALU_PASSB;
            end
            default: legal = 1'b0;
        endcase
        // Anything unrecognised becomes a harmless bubble tagged as illegal.
        if (!legal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

    assign imm   = XLEN'(gen_imm(ctrl.imm_sel, InstrD));
    assign imm_b = XLEN'(gen_imm(IMM_B, InstrD));
    assign imm_j = XLEN'(gen_imm(IMM_J, InstrD));

    assign cmp_a     = ForwardAD ? ALUOutM : rd1;
    assign cmp_b     = ForwardBD ? ALUOutM : rd2;
    assign PCSrcD    = (ctrl.branch & ((cmp_a == cmp_b) ^ ctrl.branch_ne)) | ctrl.jump;
    assign PCBranchD = PCPD - XLEN'(4) + (ctrl.jump ? imm_j : imm_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            IllegalE    <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmE        <= '0;
            PCPE        <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
        end else begin
            RegWriteE   <= ctrl.reg_write;
            MemWriteE   <= ctrl.mem_write;
            ALUSrcE     <= ctrl.alu_src;
            IllegalE    <= ctrl.illegal;
            ResultSrcE  <= ctrl.result_src;
            ALUControlE <= ctrl.alu_control;
            RD1E        <= rd1;
            RD2E        <= rd2;
            ImmE        <= imm;
            PCPE        <= PCPD;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= InstrD[11:7];
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Vector-table bench for decode_stage with a register-file model and an
// expected queue for the ID/EX outputs.
module tb_decode_stage;

    localparam int W = 153;

    localparam logic [6:0] O_OP   = 7'b0110011;
    localparam logic [6:0] O_OPI  = 7'b0010011;
    localparam logic [6:0] O_LD   = 7'b0000011;
    localparam logic [6:0] O_LUI  = 7'b0110111;

    logic        clk;
    logic        rst_n;
    logic [31:0] InstrD, PCPD, ResultW, ALUOutM;
    logic        RegWriteW, ForwardAD, ForwardBD, FlushE;
    logic [4:0]  WriteRegW;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic [4:0]  Rs1D, Rs2D;
    logic        RegWriteE, MemWriteE, ALUSrcE, IllegalE;
    logic [1:0]  ResultSrcE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmE, PCPE;
    logic [4:0]  Rs1E, Rs2E, RdE;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pcp;
        logic [31:0] alu_m;
        logic [31:0] wb_data;
        logic        fwd_a;
        logic        fwd_b;
        logic        wb_en;
        logic        flush;
        logic [4:0]  wb_reg;
        logic        chk_br;
        logic        exp_pcsrc;
        logic [31:0] exp_target;
        logic [9:0]  exp_ctl;
        logic [31:0] exp_imm;
    } vec_t;

    vec_t        tbl[$];
    logic [W-1:0] exp_q[$];
    logic [31:0] model[32];
    int          errors = 0;
    int          checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCPD(PCPD),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
        .ALUOutM(ALUOutM), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .FlushE(FlushE), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .IllegalE(IllegalE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE),
        .PCPE(PCPE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, O_OP};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [9:0] ctl(input logic rw, input logic mw, input logic as,
                                       input logic ill, input logic [1:0] rs,
                                       input logic [3:0] alu);
        return {rw, mw, as, ill, rs, alu};
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] instr,
                                input logic [9:0] c, input logic [31:0] imm);
        vec_t v;
        v.name = n;          v.instr = instr;     v.pcp = 32'h100;
        v.alu_m = '0;        v.wb_data = '0;      v.fwd_a = 1'b0;
        v.fwd_b = 1'b0;      v.wb_en = 1'b0;      v.flush = 1'b0;
        v.wb_reg = '0;       v.chk_br = 1'b0;     v.exp_pcsrc = 1'b0;
        v.exp_target = '0;   v.exp_ctl = c;       v.exp_imm = imm;
        return v;
    endfunction

    function automatic logic [W-1:0] e_bus();
        return {RegWriteE, MemWriteE, ALUSrcE, IllegalE, ResultSrcE, ALUControlE,
                RD1E, RD2E, ImmE, PCPE, Rs1E, Rs2E, RdE};
    endfunction

    task automatic check(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic idle();
        InstrD = '0; PCPD = '0; ResultW = '0; ALUOutM = '0;
        RegWriteW = 1'b0; WriteRegW = '0; ForwardAD = 1'b0; ForwardBD = 1'b0; FlushE = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        logic [W-1:0] e;
        logic [31:0]  rd1, rd2;
        logic [4:0]   rs1, rs2;
        @(negedge clk);
        InstrD = v.instr;  PCPD = v.pcp;  ALUOutM = v.alu_m;
        ForwardAD = v.fwd_a;  ForwardBD = v.fwd_b;  FlushE = v.flush;
        RegWriteW = v.wb_en;  WriteRegW = v.wb_reg;  ResultW = v.wb_data;
        #1;
        rs1 = v.instr[19:15];
        rs2 = v.instr[24:20];
        check({v.name, "_rsd"}, W'({Rs1D, Rs2D}), W'({rs1, rs2}));
        check({v.name, "_pcsrc"}, W'(PCSrcD), W'(v.exp_pcsrc));
        if (v.chk_br) check({v.name, "_target"}, W'(PCBranchD), W'(v.exp_target));
        rd1 = (v.wb_en && v.wb_reg == rs1 && rs1 != 5'd0) ? v.wb_data : model[rs1];
        rd2 = (v.wb_en && v.wb_reg == rs2 && rs2 != 5'd0) ? v.wb_data : model[rs2];
        e = v.flush ? '0 : {v.exp_ctl, rd1, rd2, v.exp_imm, v.pcp, rs1, rs2, v.instr[11:7]};
        exp_q.push_back(e);
        @(posedge clk);
        if (v.wb_en && v.wb_reg != 5'd0) model[v.wb_reg] = v.wb_data;
        #1;
        check({v.name, "_idex"}, e_bus(), exp_q.pop_front());
    endtask

    initial begin
        vec_t v;
        logic [4:0]  r;
        logic [31:0] d;
        for (int i = 0; i < 32; i++) model[i] = '0;
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_idex", e_bus(), '0);
        rst_n = 1'b1;

        v = mk("addi_wb_x1", enc_i(12'd5, 5'd0, 3'b000, 5'd1, O_OPI), ctl(1,0,1,0,2'b00,4'b0000), 32'd5);
        v.wb_en = 1'b1; v.wb_reg = 5'd1; v.wb_data = 32'd7; tbl.push_back(v);
        v = mk("beq_taken", enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000), ctl(0,0,0,0,2'b00,4'b0001), 32'hFFFF_FFF8);
        v.pcp = 32'h104; v.wb_en = 1'b1; v.wb_reg = 5'd2; v.wb_data = 32'd7;
        v.chk_br = 1'b1; v.exp_pcsrc = 1'b1; v.exp_target = 32'hF8; tbl.push_back(v);
        v = mk("beq_not", enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000), ctl(0,0,0,0,2'b00,4'b0001), 32'hFFFF_FFF8);
        v.pcp = 32'h104; v.wb_en = 1'b1; v.wb_reg = 5'd2; v.wb_data = 32'd8;
        v.chk_br = 1'b1; v.exp_target = 32'hF8; tbl.push_back(v);
        v = mk("bne_fwd_a", enc_b(13'd12, 5'd2, 5'd1, 3'b001), ctl(0,0,0,0,2'b00,4'b0001), 32'd12);
        v.wb_en = 1'b1; v.wb_reg = 5'd2; v.wb_data = 32'd9; v.fwd_a = 1'b1; v.alu_m = 32'd9;
        v.chk_br = 1'b1; v.exp_target = 32'h108; tbl.push_back(v);
        v = mk("bne_taken", enc_b(13'd12, 5'd2, 5'd1, 3'b001), ctl(0,0,0,0,2'b00,4'b0001), 32'd12);
        v.chk_br = 1'b1; v.exp_pcsrc = 1'b1; v.exp_target = 32'h108; tbl.push_back(v);
        v = mk("beq_fwd_b", enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000), ctl(0,0,0,0,2'b00,4'b0001), 32'hFFFF_FFF8);
        v.pcp = 32'h104; v.fwd_b = 1'b1; v.alu_m = 32'd7;
        v.chk_br = 1'b1; v.exp_pcsrc = 1'b1; v.exp_target = 32'hF8; tbl.push_back(v);
        v = mk("jal_fwd", enc_j(21'd16, 5'd1), ctl(1,0,0,0,2'b10,4'b0000), 32'd16);
        v.pcp = 32'h20; v.chk_br = 1'b1; v.exp_pcsrc = 1'b1; v.exp_target = 32'h2C; tbl.push_back(v);
        v = mk("jal_back", enc_j(21'h1F_F800, 5'd0), ctl(1,0,0,0,2'b10,4'b0000), 32'hFFFF_F800);
        v.pcp = 32'h1000; v.chk_br = 1'b1; v.exp_pcsrc = 1'b1; v.exp_target = 32'h7FC; tbl.push_back(v);
        v = mk("add_bypass", enc_r(7'h00, 5'd3, 5'd3, 3'b000, 5'd4), ctl(1,0,0,0,2'b00,4'b0000), '0);
        v.wb_en = 1'b1; v.wb_reg = 5'd3; v.wb_data = 32'hDEAD_BEEF; tbl.push_back(v);
        tbl.push_back(mk("sub", enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd5), ctl(1,0,0,0,2'b00,4'b0001), '0));
        tbl.push_back(mk("and", enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd12), ctl(1,0,0,0,2'b00,4'b0010), '0));
        tbl.push_back(mk("or",  enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd12), ctl(1,0,0,0,2'b00,4'b0011), '0));
        tbl.push_back(mk("xor", enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd12), ctl(1,0,0,0,2'b00,4'b0100), '0));
        tbl.push_back(mk("slt", enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd12), ctl(1,0,0,0,2'b00,4'b0101), '0));
        tbl.push_back(mk("sll", enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd12), ctl(1,0,0,0,2'b00,4'b0110), '0));
        tbl.push_back(mk("srl", enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd12), ctl(1,0,0,0,2'b00,4'b0111), '0));
        tbl.push_back(mk("sra", enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd12), ctl(1,0,0,0,2'b00,4'b1000), '0));
        tbl.push_back(mk("srai", enc_i(12'h404, 5'd3, 3'b101, 5'd6, O_OPI), ctl(1,0,1,0,2'b00,4'b1000), 32'h404));
        tbl.push_back(mk("xori", enc_i(12'hFFF, 5'd1, 3'b100, 5'd13, O_OPI), ctl(1,0,1,0,2'b00,4'b0100), 32'hFFFF_FFFF));
        tbl.push_back(mk("andi", enc_i(12'h0F0, 5'd1, 3'b111, 5'd13, O_OPI), ctl(1,0,1,0,2'b00,4'b0010), 32'h0F0));
        tbl.push_back(mk("ori",  enc_i(12'h7FF, 5'd1, 3'b110, 5'd13, O_OPI), ctl(1,0,1,0,2'b00,4'b0011), 32'h7FF));
        tbl.push_back(mk("slti", enc_i(12'h800, 5'd1, 3'b010, 5'd13, O_OPI), ctl(1,0,1,0,2'b00,4'b0101), 32'hFFFF_F800));
        tbl.push_back(mk("slli", enc_i(12'h005, 5'd1, 3'b001, 5'd13, O_OPI), ctl(1,0,1,0,2'b00,4'b0110), 32'd5));
        tbl.push_back(mk("lw",  enc_i(12'hFFC, 5'd1, 3'b010, 5'd7, O_LD), ctl(1,0,1,0,2'b01,4'b0000), 32'hFFFF_FFFC));
        tbl.push_back(mk("sw",  enc_s(12'd8, 5'd3, 5'd1), ctl(0,1,1,0,2'b00,4'b0000), 32'd8));
        tbl.push_back(mk("lui", {20'h12345, 5'd8, O_LUI}, ctl(1,0,1,0,2'b00,4'b1001), 32'h1234_5000));
        tbl.push_back(mk("illegal_7f", 32'h0020_80FF, ctl(0,0,0,1,2'b00,4'b0000), '0));
        tbl.push_back(mk("illegal_sltu", enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd9), ctl(0,0,0,1,2'b00,4'b0000), '0));
        v = mk("wr_x0", enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd9), ctl(1,0,0,0,2'b00,4'b0000), '0);
        v.wb_en = 1'b1; v.wb_reg = 5'd0; v.wb_data = 32'h55; tbl.push_back(v);
        tbl.push_back(mk("rd_x0", enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd10), ctl(1,0,0,0,2'b00,4'b0000), '0));
        v = mk("flush_sw", enc_s(12'd8, 5'd3, 5'd1), ctl(0,1,1,0,2'b00,4'b0000), 32'd8);
        v.flush = 1'b1; v.wb_en = 1'b1; v.wb_reg = 5'd10; v.wb_data = 32'h77; tbl.push_back(v);
        tbl.push_back(mk("after_flush", enc_r(7'h00, 5'd0, 5'd10, 3'b000, 5'd11), ctl(1,0,0,0,2'b00,4'b0000), '0));

        foreach (tbl[i]) apply(tbl[i]);

        for (int k = 0; k < 6; k++) begin
            r = 5'($urandom_range(1, 31));
            d = $urandom;
            v = mk("rnd_bypass", enc_r(7'h00, 5'd3, r, 3'b000, 5'd15), ctl(1,0,0,0,2'b00,4'b0000), '0);
            v.wb_en = 1'b1; v.wb_reg = r; v.wb_data = d;
            apply(v);
        end

        // Asynchronous reset between edges must clear ID/EX at once and wipe the registers.
        apply(mk("pre_reset", enc_i(12'h123, 5'd1, 3'b000, 5'd2, O_OPI), ctl(1,0,1,0,2'b00,4'b0000), 32'h123));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_idex", e_bus(), '0);
        idle();
        for (int i = 0; i < 32; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk("addi_after_reset", enc_i(12'd5, 5'd0, 3'b000, 5'd1, O_OPI), ctl(1,0,1,0,2'b00,4'b0000), 32'd5));
        apply(mk("rf_cleared", enc_r(7'h00, 5'd3, 5'd1, 3'b000, 5'd12), ctl(1,0,0,0,2'b00,4'b0000), '0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
